// File: rtl/osd_overlay.sv
// osd_overlay: recovers line/pixel position from frameTracker video and substitutes OVERLAY_LEVEL in a window (OSD_BORDER_EN: outline only)
module osd_overlay #(
  parameter logic [4:0]  SYNC_LEVEL    = 5'd2,
  parameter int unsigned MIN_SYNC      = 32,
  parameter int unsigned PORCH         = 96,
  parameter int unsigned WIN_X0        = 200,
  parameter int unsigned WIN_X1        = 400,
  parameter int unsigned WIN_Y0        = 100,
  parameter int unsigned WIN_Y1        = 150,
  parameter logic [4:0]  OVERLAY_LEVEL = 5'd28,
  parameter int unsigned LINE_MAX      = 511
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] analogValue,
  input  logic       newFrame,
  output logic [4:0] videoOut,
  output logic       inWindow,
  output logic [8:0] line
);
  typedef enum logic [2:0] {S_WAIT_FRAME, S_WAIT_SYNC, S_IN_SYNC, S_PORCH, S_ACTIVE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  sync_cnt_q, sync_cnt_d;
  logic [6:0]  porch_cnt_q, porch_cnt_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  line_q, line_d;
  logic [4:0]  video_q, video_d;
  logic        in_win_q, in_win_d;
  logic        is_sync, sync_hit, in_rect;
  assign is_sync  = analogValue <= SYNC_LEVEL;
  assign sync_hit = is_sync && 32'(sync_cnt_q) >= MIN_SYNC - 1;
  assign in_rect  = state_q == S_ACTIVE && !is_sync &&
                    32'(x_q) >= WIN_X0 && 32'(x_q) < WIN_X1 &&
                    32'(line_q) >= WIN_Y0 && 32'(line_q) < WIN_Y1;
  always_comb begin
    state_d     = state_q;
    porch_cnt_d = porch_cnt_q;
    x_d         = x_q;
    line_d      = line_q;
    sync_cnt_d  = !is_sync ? 6'd0 : (32'(sync_cnt_q) >= MIN_SYNC ? sync_cnt_q : sync_cnt_q + 6'd1);
    case (state_q)
      S_WAIT_FRAME: state_d = S_WAIT_FRAME;
      S_WAIT_SYNC:  state_d = sync_hit ? S_IN_SYNC : S_WAIT_SYNC;
      S_IN_SYNC: begin
        state_d     = is_sync ? S_IN_SYNC : S_PORCH;
        porch_cnt_d = 7'd0;
      end
      S_PORCH: begin
        porch_cnt_d = porch_cnt_q + 7'd1;
        if (32'(porch_cnt_q) + 1 >= PORCH - 1) begin
          state_d = S_ACTIVE;
          x_d     = 10'd0;
        end
      end
      S_ACTIVE: begin
        x_d = (x_q == 10'h3ff) ? x_q : x_q + 10'd1;
        if (sync_hit) begin
          state_d = S_IN_SYNC;
          line_d  = (32'(line_q) >= LINE_MAX) ? line_q : line_q + 9'd1;
        end
      end
      default: state_d = S_WAIT_FRAME;
    endcase
    // a frame start overrides any sync accepted on the same sample
    if (newFrame) begin
      state_d    = S_WAIT_SYNC;
      line_d     = 9'd0;
      sync_cnt_d = 6'd0;
    end
`ifdef OSD_BORDER_EN
    in_win_d = in_rect && (32'(x_q) == WIN_X0 || 32'(x_q) == WIN_X1 - 1 ||
                           32'(line_q) == WIN_Y0 || 32'(line_q) == WIN_Y1 - 1);
`else
    in_win_d = in_rect;
`endif
    video_d = in_win_d ? OVERLAY_LEVEL : analogValue;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_FRAME;
      sync_cnt_q  <= 6'd0;
      porch_cnt_q <= 7'd0;
      x_q         <= 10'd0;
      line_q      <= 9'd0;
      video_q     <= 5'd0;
      in_win_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      porch_cnt_q <= porch_cnt_d;
      x_q         <= x_d;
      line_q      <= line_d;
      video_q     <= video_d;
      in_win_q    <= in_win_d;
    end
  end
  assign videoOut = video_q;
  assign inWindow = in_win_q;
  assign line     = line_q;
endmodule
